// File: rtl/muldiv_unit_if.sv
// EX-stage to multiply/divide unit connection: operation request, HI/LO
// moves and the result/status signals returned to the pipeline.
interface muldiv_unit_if #(parameter int unsigned WIDTH = 32);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             hilo_rd;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             cancel;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             stall;

    modport master (
        output start, op, rs_val, rt_val, hilo_rd, hi_we, lo_we, wdata, cancel,
        input  hi, lo, busy, done, stall
    );

    modport slave (
        input  start, op, rs_val, rt_val, hilo_rd, hi_we, lo_we, wdata, cancel,
        output hi, lo, busy, done, stall
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO; one shift-add or
// restoring shift-subtract step per cycle, sign fix-up in a final cycle.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    muldiv_unit_if.slave  bus
);
    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t             state;
    state_t             state_n;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   rs_lat;
    logic               is_div;
    logic               neg_res;
    logic               neg_rem;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic               done_r;

    logic               sa;
    logic               sb;
    logic [WIDTH-1:0]   a_in;
    logic [WIDTH-1:0]   b_in;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     r_shift;
    logic [WIDTH-1:0]   diff;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;
    logic               accept;

    assign accept = bus.start && !bus.cancel;

    // op[0]=0 selects the signed variants
    always_comb begin
        sa   = !bus.op[0] && bus.rs_val[WIDTH-1];
        sb   = !bus.op[0] && bus.rt_val[WIDTH-1];
        a_in = sa ? -bus.rs_val : bus.rs_val;
        b_in = sb ? -bus.rt_val : bus.rt_val;
    end

    // acc holds {upper, lower}: product high half and unconsumed multiplier
    // for multiply, partial remainder and dividend/quotient bits for divide.
    always_comb begin
        add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, b_mag};
        mul_next = acc[0] ? {add_sum, acc[WIDTH-1:1]}
                          : {1'b0, acc[2*WIDTH-1:WIDTH], acc[WIDTH-1:1]};
        r_shift  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff     = r_shift[WIDTH-1:0] - b_mag;
        if (r_shift >= {1'b0, b_mag}) begin
            div_next = {diff, acc[WIDTH-2:0], 1'b1};
        end else begin
            div_next = {r_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        prod   = neg_res ? -acc : acc;
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
        if (is_div) begin
            if (b_mag == '0) begin
                res_lo = '1;
                res_hi = rs_lat;
            end else begin
                res_lo = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
                res_hi = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (accept) state_n = CALC;
            CALC: begin
                if (bus.cancel) begin
                    state_n = IDLE;
                end else if (cnt == CW'(WIDTH-1)) begin
                    state_n = FIX;
                end
            end
            FIX:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            acc     <= '0;
            b_mag   <= '0;
            rs_lat  <= '0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            hi_r    <= '0;
            lo_r    <= '0;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.hi_we) hi_r <= bus.wdata;
                    if (bus.lo_we) lo_r <= bus.wdata;
                    if (accept) begin
                        is_div  <= bus.op[1];
                        neg_res <= sa ^ sb;
                        neg_rem <= sa;
                        acc     <= {{WIDTH{1'b0}}, a_in};
                        b_mag   <= b_in;
                        rs_lat  <= bus.rs_val;
                        cnt     <= '0;
                    end
                end
                CALC: begin
                    if (bus.cancel) begin
                        cnt <= '0;
                    end else begin
                        acc <= is_div ? div_next : mul_next;
                        cnt <= cnt + CW'(1);
                    end
                end
                FIX: begin
                    if (!bus.cancel) begin
                        hi_r   <= res_hi;
                        lo_r   <= res_lo;
                        done_r <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.hi    = hi_r;
    assign bus.lo    = lo_r;
    assign bus.done  = done_r;
    assign bus.busy  = (state != IDLE);
    assign bus.stall = bus.busy && (bus.start || bus.hilo_rd || bus.hi_we || bus.lo_we);
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: arithmetic vectors, latency, stall,
// MTHI/MTLO, cancel and mid-operation reset.
module tb_muldiv_unit;
    localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    muldiv_unit_if #(.WIDTH(32)) bus ();
    muldiv_unit #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs [9] = '{
        '{MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB},
        '{DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD},
        '{DIVU,  32'd100,      32'h00000000, 32'd100,      32'hFFFFFFFF},
        '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000},
        '{MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000},
        '{DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD},
        '{DIV,   32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF},
        '{MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780},
        '{DIVU,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF}
    };

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issues one operation and waits (bounded) for done; lat = edges after
    // the start edge until done is seen, -1 on timeout.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int bcnt);
        bus.op = op; bus.rs_val = a; bus.rt_val = b; bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        bcnt = bus.busy ? 1 : 0;
        lat = -1;
        for (int n = 1; n <= 60; n++) begin
            tick;
            if (bus.busy) bcnt++;
            if (bus.done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick; tick;
        rst = 1'b0;
        #1;
        vectors++; if (bus.hi !== 32'h0) begin miscompares++; $display("FAIL reset_hi: got %h want 00000000", bus.hi); end
        vectors++; if (bus.lo !== 32'h0) begin miscompares++; $display("FAIL reset_lo: got %h want 00000000", bus.lo); end
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", bus.done); end
    endtask

    task automatic test_multu;
        int lat, bcnt;
        run_op(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bcnt);
        vectors++; if (lat !== 33) begin miscompares++; $display("FAIL multu_latency: got %0d want 33", lat); end
        vectors++; if (bcnt !== 33) begin miscompares++; $display("FAIL multu_busy_cycles: got %0d want 33", bcnt); end
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL multu_busy_at_done: got %b want 0", bus.busy); end
        vectors++; if (bus.hi !== 32'hFFFFFFFE) begin miscompares++; $display("FAIL multu_hi: got %h want fffffffe", bus.hi); end
        vectors++; if (bus.lo !== 32'h00000001) begin miscompares++; $display("FAIL multu_lo: got %h want 00000001", bus.lo); end
        tick;
        vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL multu_done_pulse: got %b want 0", bus.done); end
    endtask

    task automatic test_arith;
        int lat, bcnt;
        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bcnt);
            vectors++; if (lat !== 33) begin miscompares++; $display("FAIL arith%0d_latency: got %0d want 33", i, lat); end
            vectors++; if (bus.hi !== vecs[i].hi) begin miscompares++; $display("FAIL arith%0d_hi: got %h want %h", i, bus.hi, vecs[i].hi); end
            vectors++; if (bus.lo !== vecs[i].lo) begin miscompares++; $display("FAIL arith%0d_lo: got %h want %h", i, bus.lo, vecs[i].lo); end
        end
    endtask

    task automatic test_back_to_back;
        int n, bad, lat, bcnt;
        bus.op = DIVU; bus.rs_val = 32'd100; bus.rt_val = 32'd7; bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        tick; tick; tick; tick;
        // cycle 5: MFLO-style read plus a second start held by the stalled pipe
        bus.hilo_rd = 1'b1;
        bus.op = MULTU; bus.rs_val = 32'd6; bus.rt_val = 32'd7; bus.start = 1'b1;
        #1;
        n = 0; bad = 0;
        while (bus.busy && n < 60) begin
            if (bus.stall !== 1'b1) bad++;
            tick; #1;
            n++;
        end
        vectors++; if (bad !== 0) begin miscompares++; $display("FAIL b2b_stall_while_busy: got %0d unstalled cycles want 0", bad); end
        vectors++; if (n !== 29) begin miscompares++; $display("FAIL b2b_busy_span: got %0d want 29", n); end
        vectors++; if (bus.stall !== 1'b0) begin miscompares++; $display("FAIL b2b_stall_idle: got %b want 0", bus.stall); end
        vectors++; if (bus.done !== 1'b1) begin miscompares++; $display("FAIL b2b_done: got %b want 1", bus.done); end
        vectors++; if (bus.lo !== 32'd14) begin miscompares++; $display("FAIL b2b_lo: got %h want 0000000e", bus.lo); end
        vectors++; if (bus.hi !== 32'd2) begin miscompares++; $display("FAIL b2b_hi: got %h want 00000002", bus.hi); end
        bus.hilo_rd = 1'b0;
        tick;
        bus.start = 1'b0;
        #1;
        vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL b2b_retry_accept: got %b want 1", bus.busy); end
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            tick;
            if (bus.done) begin lat = k; break; end
        end
        bcnt = lat;
        vectors++; if (bcnt !== 33) begin miscompares++; $display("FAIL b2b_second_latency: got %0d want 33", bcnt); end
        vectors++; if (bus.lo !== 32'd42) begin miscompares++; $display("FAIL b2b_second_lo: got %h want 0000002a", bus.lo); end
        vectors++; if (bus.hi !== 32'd0) begin miscompares++; $display("FAIL b2b_second_hi: got %h want 00000000", bus.hi); end
    endtask

    task automatic test_mtlo;
        int n, bad;
        bus.lo_we = 1'b1; bus.wdata = 32'h1234;
        tick;
        bus.lo_we = 1'b0;
        vectors++; if (bus.lo !== 32'h1234) begin miscompares++; $display("FAIL mtlo_idle_lo: got %h want 00001234", bus.lo); end
        vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL mtlo_idle_done: got %b want 0", bus.done); end
        bus.op = MULTU; bus.rs_val = 32'd2; bus.rt_val = 32'd3; bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        bus.lo_we = 1'b1; bus.wdata = 32'hABCD;
        #1;
        vectors++; if (bus.stall !== 1'b1) begin miscompares++; $display("FAIL mtlo_busy_stall: got %b want 1", bus.stall); end
        n = 0; bad = 0;
        while (bus.busy && n < 60) begin
            if (bus.lo !== 32'h1234) bad++;
            tick; #1;
            n++;
        end
        vectors++; if (bad !== 0) begin miscompares++; $display("FAIL mtlo_busy_lo_held: got %0d changed cycles want 0", bad); end
        vectors++; if (bus.lo !== 32'd6) begin miscompares++; $display("FAIL mtlo_op_result: got %h want 00000006", bus.lo); end
        vectors++; if (bus.stall !== 1'b0) begin miscompares++; $display("FAIL mtlo_idle_stall: got %b want 0", bus.stall); end
        tick;
        bus.lo_we = 1'b0;
        #1;
        vectors++; if (bus.lo !== 32'hABCD) begin miscompares++; $display("FAIL mtlo_retry_lo: got %h want 0000abcd", bus.lo); end
        vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL mtlo_retry_done: got %b want 0", bus.done); end
    endtask

    task automatic test_cancel;
        int dn;
        bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'h5A5A5A5A;
        tick;
        bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        bus.op = MULT; bus.rs_val = 32'd5; bus.rt_val = 32'd9; bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        repeat (8) tick;
        bus.cancel = 1'b1;
        tick;
        bus.cancel = 1'b0;
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL cancel_calc_busy: got %b want 0", bus.busy); end
        vectors++; if (bus.hi !== 32'h5A5A5A5A) begin miscompares++; $display("FAIL cancel_calc_hi: got %h want 5a5a5a5a", bus.hi); end
        vectors++; if (bus.lo !== 32'h5A5A5A5A) begin miscompares++; $display("FAIL cancel_calc_lo: got %h want 5a5a5a5a", bus.lo); end
        dn = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) dn++;
            tick;
        end
        vectors++; if (dn !== 0) begin miscompares++; $display("FAIL cancel_calc_quiet: got %0d active cycles want 0", dn); end
        // cancel arriving in the fix-up cycle
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        repeat (32) tick;
        vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL cancel_fix_busy_before: got %b want 1", bus.busy); end
        bus.cancel = 1'b1;
        tick;
        bus.cancel = 1'b0;
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL cancel_fix_busy: got %b want 0", bus.busy); end
        vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL cancel_fix_done: got %b want 0", bus.done); end
        vectors++; if (bus.lo !== 32'h5A5A5A5A) begin miscompares++; $display("FAIL cancel_fix_lo: got %h want 5a5a5a5a", bus.lo); end
        bus.start = 1'b1; bus.cancel = 1'b1;
        tick;
        bus.start = 1'b0; bus.cancel = 1'b0;
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL cancel_idle_start: got %b want 0", bus.busy); end
    endtask

    task automatic test_rst_mid;
        bus.op = MULT; bus.rs_val = 32'd5; bus.rt_val = 32'd9; bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        repeat (8) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        vectors++; if (bus.hi !== 32'h0) begin miscompares++; $display("FAIL rstmid_hi: got %h want 00000000", bus.hi); end
        vectors++; if (bus.lo !== 32'h0) begin miscompares++; $display("FAIL rstmid_lo: got %h want 00000000", bus.lo); end
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy: got %b want 0", bus.busy); end
        repeat (40) tick;
        vectors++; if (bus.lo !== 32'h0) begin miscompares++; $display("FAIL rstmid_no_late_write: got %h want 00000000", bus.lo); end
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0; bus.op = 2'b00; bus.rs_val = '0; bus.rt_val = '0;
        bus.hilo_rd = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        bus.wdata = '0; bus.cancel = 1'b0;
        test_reset;
        test_multu;
        test_arith;
        test_back_to_back;
        test_mtlo;
        test_cancel;
        test_rst_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end
endmodule
